// File: rtl/clk_div_gen_if.sv
// Divisor request and divided-clock status bundle between the upstream
// configuration source (master) and the clock divider (slave).
interface clk_div_gen_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] div_data_i;
    logic             div_en_i;
    logic             div_clk_o;
    logic             tick_o;
    logic             upd_ack_o;
    logic             pend_o;
    logic [WIDTH-1:0] div_cur_o;

    modport master (
        output div_data_i, div_en_i,
        input  div_clk_o, tick_o, upd_ack_o, pend_o, div_cur_o
    );

    modport slave (
        input  div_data_i, div_en_i,
        output div_clk_o, tick_o, upd_ack_o, pend_o, div_cur_o
    );
endinterface

// File: rtl/clk_div_gen.sv
// Programmable clock divider: registered divided clock plus period tick, with
// divisor updates deferred to a period boundary so no period is truncated.
module clk_div_gen #(
    parameter int WIDTH   = 8,
    parameter int RST_DIV = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    clk_div_gen_if.slave  bus
);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RST_DIV);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_div_cur;
    logic [WIDTH-1:0] r_pend_div;
    logic             r_pend;
    logic             r_started;
    logic             r_div_clk;
    logic             r_tick;
    logic             r_upd_ack;

    logic             w_bnd;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_div_nxt;
    logic [WIDTH-1:0] w_pend_div_nxt;
    logic             w_pend_nxt;
    logic             w_ack_nxt;
    logic [WIDTH:0]   w_half;
    logic             w_div_clk_nxt;
    logic             w_tick_nxt;

    // The first edge after reset is treated as a boundary so the first period
    // starts cleanly at cnt=0; a stopped divider (N=0) is a boundary every edge.
    assign w_bnd = !r_started || (r_div_cur == '0) || (r_cnt == r_div_cur - 1'b1);

    always_comb begin
        w_cnt_nxt      = r_cnt + 1'b1;
        w_div_nxt      = r_div_cur;
        w_pend_nxt     = r_pend;
        w_pend_div_nxt = r_pend_div;
        w_ack_nxt      = 1'b0;
        if (w_bnd) begin
            w_cnt_nxt = '0;
            if (bus.div_en_i) begin
                // A strobe landing on the boundary wins over any older pending value.
                w_div_nxt  = bus.div_data_i;
                w_pend_nxt = 1'b0;
                w_ack_nxt  = 1'b1;
            end else if (r_pend) begin
                w_div_nxt  = r_pend_div;
                w_pend_nxt = 1'b0;
                w_ack_nxt  = 1'b1;
            end
        end else if (bus.div_en_i) begin
            w_pend_nxt     = 1'b1;
            w_pend_div_nxt = bus.div_data_i;
        end
    end

    // Outputs are computed from next-state so they line up with cnt in each cycle.
    assign w_half        = ({1'b0, w_div_nxt} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
    assign w_div_clk_nxt = ({1'b0, w_cnt_nxt} < w_half);
    assign w_tick_nxt    = (w_div_nxt != '0) && (w_cnt_nxt == w_div_nxt - 1'b1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt      <= '0;
            r_div_cur  <= RST_VAL;
            r_pend_div <= '0;
            r_pend     <= 1'b0;
            r_started  <= 1'b0;
            r_div_clk  <= 1'b0;
            r_tick     <= 1'b0;
            r_upd_ack  <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_div_cur  <= w_div_nxt;
            r_pend_div <= w_pend_div_nxt;
            r_pend     <= w_pend_nxt;
            r_started  <= 1'b1;
            r_div_clk  <= w_div_clk_nxt;
            r_tick     <= w_tick_nxt;
            r_upd_ack  <= w_ack_nxt;
        end
    end

    assign bus.div_clk_o = r_div_clk;
    assign bus.tick_o    = r_tick;
    assign bus.upd_ack_o = r_upd_ack;
    assign bus.pend_o    = r_pend;
    assign bus.div_cur_o = r_div_cur;
endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen: each scenario steps cycle by cycle and
// compares {div_clk, tick, upd_ack, pend, div_cur} against hand-derived patterns.
module tb_clk_div_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    clk_div_gen_if #(.WIDTH(8)) bus();

    clk_div_gen #(.WIDTH(8), .RST_DIV(1)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] obs();
        return {bus.div_clk_o, bus.tick_o, bus.upd_ack_o, bus.pend_o, bus.div_cur_o};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] n);
        bus.div_en_i   = 1'b1;
        bus.div_data_i = n;
    endtask

    task automatic idle();
        bus.div_en_i   = 1'b0;
        bus.div_data_i = 8'h01;
    endtask

    task automatic test_reset();
        logic [11:0] e;
        idle();
        rst = 1'b1;
        cyc();
        cyc();
        e = {4'b0000, 8'd1};
        n_vec++;
        if (obs() !== e) begin
            n_err++;
            $display("FAIL reset_state got %b exp %b", obs(), e);
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            e = {4'b1100, 8'd1};
            n_vec++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL reset_n1 i=%0d got %b exp %b", i, obs(), e);
            end
        end
    endtask

    // N=1 runs boundary every edge, so a strobe of 4 applies at once.
    task automatic test_n4();
        logic [11:0] e;
        strobe(8'd4);
        cyc();
        idle();
        for (int i = 0; i < 12; i++) begin
            e = {((i % 4) < 2), ((i % 4) == 3), (i == 0), 1'b0, 8'd4};
            n_vec++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL n4 i=%0d got %b exp %b", i, obs(), e);
            end
            cyc();
        end
    endtask

    task automatic test_deferred();
        logic [11:0] e;
        repeat (3) cyc();
        strobe(8'd6);
        cyc();
        idle();
        for (int i = 0; i < 15; i++) begin
            if (i < 6)
                e = {(i < 3), (i == 5), (i == 0), (i >= 3), 8'd6};
            else
                e = {(((i - 6) % 3) < 2), (((i - 6) % 3) == 2), (i == 6), 1'b0, 8'd3};
            n_vec++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL deferred i=%0d got %b exp %b", i, obs(), e);
            end
            if (i == 2) strobe(8'd3);
            cyc();
            idle();
        end
    endtask

    task automatic test_last_wins();
        logic [11:0] e;
        repeat (2) cyc();
        strobe(8'd5);
        cyc();
        idle();
        for (int i = 0; i < 11; i++) begin
            if (i < 5)
                e = {(i < 3), (i == 4), (i == 0), (i >= 2), 8'd5};
            else
                e = {(((i - 5) % 2) == 0), (((i - 5) % 2) == 1), (i == 5), 1'b0, 8'd2};
            n_vec++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL last_wins i=%0d got %b exp %b", i, obs(), e);
            end
            if (i == 1) strobe(8'd8);
            if (i == 3) strobe(8'd2);
            cyc();
            idle();
        end
    endtask

    // Pending 9 is discarded by the strobe of 7 landing on the boundary cycle.
    task automatic test_back_to_back();
        logic [11:0] e;
        cyc();
        strobe(8'd4);
        cyc();
        idle();
        for (int i = 0; i < 18; i++) begin
            if (i < 4)
                e = {(i < 2), (i == 3), (i == 0), (i >= 2), 8'd4};
            else
                e = {(((i - 4) % 7) < 4), (((i - 4) % 7) == 6), (i == 4), 1'b0, 8'd7};
            n_vec++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL bypass i=%0d got %b exp %b", i, obs(), e);
            end
            if (i == 1) strobe(8'd9);
            if (i == 3) strobe(8'd7);
            cyc();
            idle();
        end
    endtask

    task automatic test_stop_restart();
        logic [11:0] e;
        for (int i = 0; i < 17; i++) begin
            if (i < 7)
                e = {(i < 4), (i == 6), 1'b0, (i >= 1), 8'd7};
            else if (i < 11)
                e = {2'b00, (i == 7), 1'b0, 8'd0};
            else
                e = {(((i - 11) % 3) < 2), (((i - 11) % 3) == 2), (i == 11), 1'b0, 8'd3};
            n_vec++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL stop_restart i=%0d got %b exp %b", i, obs(), e);
            end
            if (i == 0) strobe(8'd0);
            if (i == 10) strobe(8'd3);
            cyc();
            idle();
        end
        strobe(8'd5);
        cyc();
        idle();
        e = {4'b1001, 8'd3};
        n_vec++;
        if (obs() !== e) begin
            n_err++;
            $display("FAIL pre_reset got %b exp %b", obs(), e);
        end
        #2 rst = 1'b1;
        #1;
        e = {4'b0000, 8'd1};
        n_vec++;
        if (obs() !== e) begin
            n_err++;
            $display("FAIL async_reset got %b exp %b", obs(), e);
        end
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            e = {4'b1100, 8'd1};
            n_vec++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL post_reset i=%0d got %b exp %b", i, obs(), e);
            end
        end
    endtask

    task automatic test_same_value();
        logic [11:0] e;
        strobe(8'd1);
        cyc();
        idle();
        for (int i = 0; i < 3; i++) begin
            e = {2'b11, (i == 0), 1'b0, 8'd1};
            n_vec++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL same_value i=%0d got %b exp %b", i, obs(), e);
            end
            cyc();
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_n4();
        test_deferred();
        test_last_wins();
        test_back_to_back();
        test_stop_restart();
        test_same_value();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
